// File: rtl/frame_checker.sv
// Sync-word framed checksum checker: hunts for SYNC, sums FRAME_LEN payload
// words mod 2^16, compares against the trailing word, keeps saturating tallies.
//
// state | meaning
// ------+-----------------------------------------------------------
// HUNT  | discarding words until SYNC is accepted
// ACCUM | adding payload words into the running sum
// CHECK | next accepted word is the checksum; report and return to HUNT
module frame_checker #(
  parameter int          FRAME_LEN = 4,
  parameter logic [15:0] SYNC      = 16'hA5A5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        data_in_valid,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [15:0] frame_sum,
  output logic [7:0]  ok_count,
  output logic [7:0]  err_count,
  output logic        busy
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    ACCUM = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  state_t      state_q, state_d;
  logic [15:0] sum_q, sum_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        frame_ok_q, frame_ok_d;
  logic        frame_err_q, frame_err_d;
  logic [15:0] frame_sum_q, frame_sum_d;
  logic [7:0]  ok_count_q, ok_count_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= HUNT;
      sum_q       <= '0;
      cnt_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      frame_sum_q <= '0;
      ok_count_q  <= '0;
      err_count_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      frame_sum_q <= frame_sum_d;
      ok_count_q  <= ok_count_d;
      err_count_q <= err_count_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (data_in_valid) begin
      case (state_q)
        HUNT:    if (data_in == SYNC) state_d = ACCUM;
        ACCUM:   if (cnt_q == LAST_IDX) state_d = CHECK;
        CHECK:   state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  // Datapath follows the state; pulses default low so idle edges clear them.
  always_comb begin
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    frame_sum_d = frame_sum_q;
    ok_count_d  = ok_count_q;
    err_count_d = err_count_q;
    if (data_in_valid) begin
      case (state_q)
        HUNT: begin
          if (data_in == SYNC) begin
            sum_d = '0;
            cnt_d = '0;
          end
        end
        ACCUM: begin
          sum_d = sum_q + data_in;
          cnt_d = cnt_q + 8'd1;
        end
        CHECK: begin
          frame_sum_d = sum_q;
          if (data_in == sum_q) begin
            frame_ok_d = 1'b1;
            if (ok_count_q != 8'hFF) ok_count_d = ok_count_q + 8'd1;
          end else begin
            frame_err_d = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d != HUNT);
  end

  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign frame_sum = frame_sum_q;
  assign ok_count  = ok_count_q;
  assign err_count = err_count_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_frame_checker.sv
// Directed bench for frame_checker: hand-computed frames, gaps, resets, saturation.
module tb_frame_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data_in = '0;
  logic        data_in_valid = 1'b0;
  logic        frame_ok, frame_err, busy;
  logic [15:0] frame_sum;
  logic [7:0]  ok_count, err_count;

  int n_chk = 0;
  int n_bad = 0;

  frame_checker dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .frame_ok(frame_ok), .frame_err(frame_err), .frame_sum(frame_sum),
    .ok_count(ok_count), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Present one word for one edge; outputs are sampled 1 time unit after it.
  task automatic word(input logic [15:0] d);
    data_in = d;
    data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    data_in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  int pulses;
  int stray;
  int errs;

  initial begin
    do_reset();
    chk("rst_ok", frame_ok, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_sum", frame_sum, 0);
    chk("rst_okc", ok_count, 0);
    chk("rst_errc", err_count, 0);
    chk("rst_busy", busy, 0);

    // good frame
    word(16'hA5A5);
    chk("good_busy_after_sync", busy, 1);
    word(16'h0001); word(16'h0002); word(16'h0003); word(16'h0004);
    chk("good_no_early_pulse", frame_ok, 0);
    word(16'h000A);
    chk("good_ok", frame_ok, 1);
    chk("good_err", frame_err, 0);
    chk("good_sum", frame_sum, 16'h000A);
    chk("good_okc", ok_count, 1);
    chk("good_errc", err_count, 0);
    chk("good_busy", busy, 0);
    idle(1);
    chk("good_pulse_end", frame_ok, 0);
    chk("good_sum_held", frame_sum, 16'h000A);

    // bad checksum
    word(16'hA5A5);
    word(16'h0001); word(16'h0002); word(16'h0003); word(16'h0004);
    word(16'h000B);
    chk("bad_err", frame_err, 1);
    chk("bad_ok", frame_ok, 0);
    chk("bad_sum", frame_sum, 16'h000A);
    chk("bad_errc", err_count, 1);
    chk("bad_okc", ok_count, 1);
    idle(1);
    chk("bad_pulse_end", frame_err, 0);

    // hunt discard + wraparound sum
    word(16'h1234);
    word(16'h0000);
    chk("hunt_busy", busy, 0);
    word(16'hA5A5);
    word(16'hFFFF); word(16'h0002); word(16'h0000); word(16'h0000);
    word(16'h0001);
    chk("wrap_ok", frame_ok, 1);
    chk("wrap_sum", frame_sum, 16'h0001);
    chk("wrap_okc", ok_count, 2);

    // gaps and sync-valued payload/checksum
    pulses = 0;
    word(16'hA5A5);
    idle(3);
    chk("gap_busy_hold", busy, 1);
    word(16'hA5A5);
    idle(3);
    chk("gap_busy_payload", busy, 1);
    word(16'h0000); idle(3);
    word(16'h0000); idle(3);
    word(16'h0000); idle(3);
    chk("gap_busy_check", busy, 1);
    chk("gap_no_pulse_yet", frame_ok, 0);
    word(16'hA5A5);
    if (frame_ok) pulses++;
    idle(3);
    if (frame_ok) pulses++;
    chk("gap_pulses", pulses, 1);
    chk("gap_sum", frame_sum, 16'hA5A5);
    chk("gap_okc", ok_count, 3);
    chk("gap_busy_done", busy, 0);

    // reset mid-frame
    word(16'hA5A5); word(16'h0001); word(16'h0002);
    do_reset();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_okc", ok_count, 0);
    chk("mid_rst_errc", err_count, 0);
    chk("mid_rst_sum", frame_sum, 0);
    word(16'hA5A5);
    word(16'h0001); word(16'h0002); word(16'h0003); word(16'h0004);
    chk("mid_no_stray", frame_ok | frame_err, 0);
    word(16'h000A);
    chk("mid_ok", frame_ok, 1);
    chk("mid_okc", ok_count, 1);

    // saturation: 260 back-to-back good frames
    do_reset();
    pulses = 0;
    stray = 0;
    errs = 0;
    for (int f = 0; f < 260; f++) begin
      word(16'hA5A5);
      if (frame_ok | frame_err) stray++;
      word(16'h0010); word(16'h0020); word(16'h0030); word(16'h0040);
      word(16'h00A0);
      if (frame_ok) pulses++;
      if (frame_err) errs++;
      if (f == 254) chk("sat_at_255", ok_count, 8'hFF);
      if (f == 253) chk("sat_at_254", ok_count, 8'hFE);
    end
    chk("sat_pulses", pulses, 260);
    chk("sat_stray", stray, 0);
    chk("sat_errs", errs, 0);
    chk("sat_okc", ok_count, 8'hFF);
    chk("sat_errc", err_count, 0);
    chk("sat_sum", frame_sum, 16'h00A0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
